// File: rtl/cache_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_wb_pkg
// Description : Shared types and default widths for the cache write buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_wb_pkg;

  localparam int WB_DEF_DEPTH  = 4;
  localparam int WB_DEF_ADDR_W = 32;
  localparam int WB_DEF_DATA_W = 32;

  // One buffered store at the default widths.
  typedef struct packed {
    logic [WB_DEF_ADDR_W-1:0] addr;
    logic [WB_DEF_DATA_W-1:0] data;
  } wb_entry_t;

  // Drain state machine states.
  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_REQ  = 1'b1
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo_mem
// Description : Entry storage for the write buffer: circular array with
//               head/tail/count plus two parallel newest-match lookups (one
//               for the read-miss port, one for the incoming store address).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo_mem
  import cache_wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEF_DEPTH,
  parameter int ADDR_W = WB_DEF_ADDR_W,
  parameter int DATA_W = WB_DEF_DATA_W,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              ovr,
  input  logic [PW-1:0]     ovr_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_q,
  output logic              wr_hit,
  output logic [PW-1:0]     wr_idx,
  output logic [PW-1:0]     head_idx,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [CW-1:0]     count
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW-1:0]     idx;

  // Storage: a new entry at the tail, or an in-place data overwrite.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= wr_addr;
      data_mem[tail] <= wr_data;
    end else if (ovr) begin
      data_mem[ovr_idx] <= wr_data;
    end
  end

  // Pointers wrap naturally (power-of-two depth); occupancy tracked by count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Walk valid entries oldest to newest so the last match is the newest one.
  always_comb begin
    rd_hit = 1'b0;
    rd_q   = '0;
    wr_hit = 1'b0;
    wr_idx = head;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < count) begin
        if (addr_mem[idx] == rd_addr) begin
          rd_hit = 1'b1;
          rd_q   = data_mem[idx];
        end
        if (addr_mem[idx] == wr_addr) begin
          wr_hit = 1'b1;
          wr_idx = idx;
        end
      end
    end
  end

  assign head_idx  = head;
  assign head_addr = addr_mem[head];
  assign head_data = data_mem[head];

endmodule
`default_nettype wire

// File: rtl/cache_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : cache_write_buffer
// Description : Write-through posting buffer behind the cache. Stores are
//               queued and drained in order to memory over req/ack; a lookup
//               port returns the newest buffered data for a read miss.
//               Optional store coalescing: define WB_COALESCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_write_buffer
  import cache_wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEF_DEPTH,
  parameter int ADDR_W = WB_DEF_ADDR_W,
  parameter int DATA_W = WB_DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        data,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_hit,
  output logic [DATA_W-1:0]        rd_q,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_state_t         state;
  wb_state_t         state_nx;
  logic              push;
  logic              pop;
  logic              ovr;
  logic              wr_hit;
  logic [PW-1:0]     wr_idx;
  logic [PW-1:0]     head_idx;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign wr_ready = (count != CW'(DEPTH));
  assign empty    = (count == '0);
  assign mem_req  = (state == WB_REQ);

`ifdef WB_COALESCE_EN
  // Merge into the newest matching entry unless it is the head already on the bus.
  assign ovr = wr && wr_hit && !((state == WB_REQ) && (wr_idx == head_idx));
`else
  assign ovr = 1'b0;
  logic unused_coalesce;
  assign unused_coalesce = &{1'b0, wr_hit, wr_idx};
`endif

  assign push = wr && wr_ready && !ovr;

  wb_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .ovr       (ovr),
    .ovr_idx   (wr_idx),
    .wr_addr   (addr),
    .wr_data   (data),
    .rd_addr   (rd_addr),
    .rd_hit    (rd_hit),
    .rd_q      (rd_q),
    .wr_hit    (wr_hit),
    .wr_idx    (wr_idx),
    .head_idx  (head_idx),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count)
  );

  // Drain FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WB_IDLE;
    else     state <= state_nx;
  end

  // Drain FSM next state and pop; IDLE leaves a one-cycle bubble between writes.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      WB_IDLE: if (count != '0) state_nx = WB_REQ;
      WB_REQ: begin
        if (mem_ack) begin
          pop      = 1'b1;
          state_nx = WB_IDLE;
        end
      end
      default: state_nx = WB_IDLE;
    endcase
  end

  // Capture the head on the IDLE->REQ edge; forward a same-edge merge into the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= '0;
      mem_data <= '0;
    end else if ((state == WB_IDLE) && (count != '0)) begin
      mem_addr <= head_addr;
      mem_data <= (ovr && (wr_idx == head_idx)) ? data : head_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_write_buffer
// Description : Directed self-checking bench for cache_write_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_write_buffer;
  import cache_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] data;
  logic        wr_ready;
  logic [31:0] rd_addr;
  logic        rd_hit;
  logic [31:0] rd_q;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;
  wb_entry_t exp_q[$];
  wb_entry_t e;

  cache_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .addr     (addr),
    .data     (data),
    .wr_ready (wr_ready),
    .rd_addr  (rd_addr),
    .rd_hit   (rd_hit),
    .rd_q     (rd_q),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_ack  (mem_ack),
    .count    (count),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    check("req_wait", mem_req, 1);
  endtask

  task automatic drain_all();
    int n = 0;
    while (!empty && n < 100) begin
      mem_ack = mem_req;
      tick();
      mem_ack = 1'b0;
      n++;
    end
    check("drain_done", empty, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr = 1'b0; addr = '0; data = '0; rd_addr = '0; mem_ack = 1'b0;
    #12;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_req", mem_req, 0);
    check("rst_ready", wr_ready, 1);
    check("rst_maddr", mem_addr, 0);
    rst = 1'b0;
    tick();

    // Single store, ack after the request has been held 3 cycles
    wr = 1'b1; addr = 32'd0; data = 32'd1;
    tick();
    wr = 1'b0;
    check("single_count", count, 1);
    check("single_req_n", mem_req, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("single_req", mem_req, 1);
      check("single_addr", mem_addr, 0);
      check("single_data", mem_data, 1);
      if (i < 2) tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("single_empty", empty, 1);
    check("single_req_off", mem_req, 0);

    // Fill with memory stalled; 5th store must be dropped
    wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = i; data = i + 1;
      tick();
    end
    check("full_ready", wr_ready, 0);
    addr = 32'd9; data = 32'd9;
    tick();
    wr = 1'b0;
    check("full_count", count, 4);
    check("full_head_addr", mem_addr, 0);
    check("full_head_data", mem_data, 1);
    rd_addr = 32'd2; #1;
    check("full_lk_hit", rd_hit, 1);
    check("full_lk_q", rd_q, 3);
    rd_addr = 32'd9; #1;
    check("full_lk_drop", rd_hit, 0);

    // Drain in order, ack one cycle in, one bubble between writes
    for (int i = 0; i < 4; i++) begin
      check("drain_req", mem_req, 1);
      check("drain_addr", mem_addr, i);
      check("drain_data", mem_data, i + 1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("drain_bubble", mem_req, 0);
      if (i < 3) tick();
    end
    check("drain_empty", empty, 1);

    // Lookup returns newest matching store
    wr = 1'b1; addr = 32'd1; data = 32'd3;
    tick();
    data = 32'd7;
    tick();
    wr = 1'b0;
    rd_addr = 32'd1; #1;
    check("lk_hit", rd_hit, 1);
    check("lk_q", rd_q, 7);
    rd_addr = 32'd5; #1;
    check("lk_miss_hit", rd_hit, 0);
    check("lk_miss_q", rd_q, 0);
    drain_all();

`ifdef WB_COALESCE_EN
    // Two stores to one address behind a stalled head merge into one entry
    wr = 1'b1; addr = 32'd8; data = 32'd1;
    tick();
    wr = 1'b0;
    tick();
    check("co_req", mem_req, 1);
    wr = 1'b1; addr = 32'd1; data = 32'd3;
    tick();
    data = 32'd7;
    tick();
    wr = 1'b0;
    check("co_count", count, 2);
    check("co_head", mem_addr, 8);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    check("co_addr", mem_addr, 1);
    check("co_data", mem_data, 7);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("co_empty", empty, 1);
`endif

    // Simultaneous push and pop at count=2, long enough to wrap pointers
    wr = 1'b1; addr = 32'd32; data = 32'd1;
    tick();
    addr = 32'd33; data = 32'd2;
    tick();
    wr = 1'b0;
    e.addr = 32'd32; e.data = 32'd1; exp_q.push_back(e);
    e.addr = 32'd33; e.data = 32'd2; exp_q.push_back(e);
    check("pp_count0", count, 2);
    for (int i = 0; i < 10; i++) begin
      wait_req();
      check("pp_addr", mem_addr, exp_q[0].addr);
      check("pp_data", mem_data, exp_q[0].data);
      wr = 1'b1; addr = 40 + i; data = 200 + i; mem_ack = 1'b1;
      tick();
      wr = 1'b0; mem_ack = 1'b0;
      void'(exp_q.pop_front());
      e.addr = 40 + i; e.data = 200 + i; exp_q.push_back(e);
      check("pp_count", count, 2);
    end
    drain_all();

    // Asynchronous reset mid-transfer
    wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = 50 + i; data = i + 1;
      tick();
    end
    wr = 1'b0;
    check("mr_count", count, 3);
    check("mr_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("mr_req_off", mem_req, 0);
    check("mr_count0", count, 0);
    check("mr_empty", empty, 1);
    check("mr_maddr", mem_addr, 0);
    check("mr_mdata", mem_data, 0);
    tick();
    rst = 1'b0;
    tick();
    check("mr_ready", wr_ready, 1);
    check("mr_idle", mem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
